// File: rtl/inst_fetch_queue_if.sv
// Instruction fetch queue bus: the cache-side push handshake, the
// decode-side pop handshake, the flush controls and the occupancy count.
// The master side drives the queue; the slave side is the queue itself.
interface inst_fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       pc_i;
  logic [30:0]       branch_target_i;
  logic [31:0]       inst_i;
  logic              fetch_error_i;
  logic              flush_i;
  logic              fence_i;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       pc_o;
  logic [30:0]       branch_target_o;
  logic [31:0]       inst_o;
  logic              fetch_error_o;
  logic              is_ctrl_o;
  logic [PTR_W:0]    count_o;

  modport master (
    output in_valid, pc_i, branch_target_i, inst_i, fetch_error_i,
           flush_i, fence_i, out_ready,
    input  in_ready, out_valid, pc_o, branch_target_o, inst_o,
           fetch_error_o, is_ctrl_o, count_o
  );

  modport slave (
    input  in_valid, pc_i, branch_target_i, inst_i, fetch_error_i,
           flush_i, fence_i, out_ready,
    output in_ready, out_valid, pc_o, branch_target_o, inst_o,
           fetch_error_o, is_ctrl_o, count_o
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between the L1 instruction cache output pipeline and
// decode. Each entry carries PC, predicted branch target, instruction word,
// fetch-error flag and a control-flow predecode bit computed at push time.
// Flush/fence.i empty the queue; reset additionally zeroes the storage.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  inst_fetch_queue_if.slave q
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [30:0] branch_target;
    logic [31:0] inst;
    logic        err;
    logic        is_ctrl;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic             flush;

  // JAL, JALR and conditional branches are the control-flow opcodes
  function automatic logic ctrl_opcode(input logic [6:0] op);
    case (op)
      7'b1101111, 7'b1100111, 7'b1100011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign q.in_ready  = (count != FULL_COUNT);
  assign q.out_valid = (count != '0);
  assign q.count_o   = count;

  assign push  = q.in_valid && q.in_ready;
  assign pop   = q.out_valid && q.out_ready;
  assign flush = q.flush_i || q.fence_i;

  assign new_entry = '{pc:            q.pc_i,
                       branch_target: q.branch_target_i,
                       inst:          q.inst_i,
                       err:           q.fetch_error_i,
                       is_ctrl:       ctrl_opcode(q.inst_i[6:0])};

  assign head              = mem[rd_ptr];
  assign q.pc_o            = head.pc;
  assign q.branch_target_o = head.branch_target;
  assign q.inst_o          = head.inst;
  assign q.fetch_error_o   = head.err;
  assign q.is_ctrl_o       = head.is_ctrl;

  // Entry storage: zeroed on reset, written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards any push/pop this cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
